// File: rtl/mem_lat_shim.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lat_shim
//  Description : Per-port latency and credit shim between TL-UL SRAM adapters
//                and single-cycle memories. Generates rvalid for reads, delays
//                read data by a fixed latency and caps in-flight reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lat_shim #(
  parameter int NumPorts       = 2,
  parameter int AddrW          = 21,
  parameter int DataW          = 32,
  parameter int Latency        = 1,
  parameter int MaxOutstanding = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumPorts-1:0]            req_i,
  input  logic [NumPorts-1:0]            we_i,
  input  logic [NumPorts-1:0][AddrW-1:0] addr_i,
  input  logic [NumPorts-1:0][DataW-1:0] wdata_i,
  input  logic [NumPorts-1:0][DataW-1:0] strb_i,
  input  logic [NumPorts-1:0]            stall_i,
  output logic [NumPorts-1:0]            gnt_o,
  output logic [NumPorts-1:0][DataW-1:0] rdata_o,
  output logic [NumPorts-1:0]            rvalid_o,
  output logic [NumPorts-1:0]            mem_req_o,
  output logic [NumPorts-1:0]            mem_we_o,
  output logic [NumPorts-1:0][AddrW-1:0] mem_addr_o,
  output logic [NumPorts-1:0][DataW-1:0] mem_wdata_o,
  output logic [NumPorts-1:0][DataW-1:0] mem_strb_o,
  input  logic [NumPorts-1:0]            mem_gnt_i,
  input  logic [NumPorts-1:0][DataW-1:0] mem_rdata_i,
  output logic [NumPorts-1:0][3:0]       outstanding_o
);

  localparam logic [3:0] c_max_out = 4'(MaxOutstanding);

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    logic       w_credit_ok;
    logic       w_rd_acc;
    logic       w_rvalid;
    logic       r_acc;
    logic [3:0] r_cnt;

    // A returning rvalid does not free credit until the following cycle.
    assign w_credit_ok    = (r_cnt < c_max_out) & ~stall_i[p];
    assign mem_req_o[p]   = req_i[p] & w_credit_ok;
    assign mem_we_o[p]    = we_i[p];
    assign mem_addr_o[p]  = addr_i[p];
    assign mem_wdata_o[p] = wdata_i[p];
    assign mem_strb_o[p]  = strb_i[p];
    assign gnt_o[p]       = mem_req_o[p] & mem_gnt_i[p];
    assign w_rd_acc       = gnt_o[p] & ~we_i[p];

    assign rvalid_o[p]      = w_rvalid;
    assign outstanding_o[p] = r_cnt;

    // Registered read-accept: marks the cycle in which memory data is valid.
    always_ff @(posedge clk_i) begin
      if (rst_i) r_acc <= 1'b0;
      else       r_acc <= w_rd_acc;
    end

    // In-flight read counter: +1 on read accept, -1 on rvalid.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_cnt <= 4'd0;
      end else if (w_rd_acc && !w_rvalid) begin
        r_cnt <= r_cnt + 4'd1;
      end else if (!w_rd_acc && w_rvalid) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end

    // Counter must stay within 0..MaxOutstanding.
    always_ff @(posedge clk_i) begin
      if (!rst_i) begin
        a_no_overflow: assert (!(w_rd_acc && !w_rvalid && (r_cnt >= c_max_out)));
        a_no_underflow: assert (!(w_rvalid && !w_rd_acc && (r_cnt == 4'd0)));
      end
    end

    if (Latency == 1) begin : g_lat1
      assign w_rvalid   = r_acc;
      assign rdata_o[p] = mem_rdata_i[p];
    end else begin : g_latn
      localparam int c_depth = Latency - 1;
      logic [c_depth-1:0]            r_pv;
      logic [c_depth-1:0][DataW-1:0] r_pd;

      // Valid/data shift line; stage 0 captures memory data with the accept bit.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_pv <= '0;
          r_pd <= '0;
        end else begin
          r_pv[0] <= r_acc;
          r_pd[0] <= mem_rdata_i[p];
          for (int i = 1; i < c_depth; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_pd[i] <= r_pd[i-1];
          end
        end
      end

      assign w_rvalid   = r_pv[c_depth-1];
      assign rdata_o[p] = r_pd[c_depth-1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_lat_shim.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mem_lat_shim
//  Description : Directed self-checking bench for mem_lat_shim using four
//                instances with different latency/credit settings.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_lat_shim;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: 2 ports, Latency 1, MaxOutstanding 2
  logic [1:0]        a_req, a_we, a_stall, a_mgnt, a_gnt, a_rvalid, a_mreq, a_mwe;
  logic [1:0][20:0]  a_addr, a_maddr;
  logic [1:0][31:0]  a_wdata, a_strb, a_mrdata, a_rdata, a_mwdata, a_mstrb;
  logic [1:0][3:0]   a_out;
  // Instance B: Latency 4, MaxOutstanding 8
  logic [0:0]        b_req, b_we, b_stall, b_mgnt, b_gnt, b_rvalid, b_mreq, b_mwe;
  logic [0:0][20:0]  b_addr, b_maddr;
  logic [0:0][31:0]  b_wdata, b_strb, b_mrdata, b_rdata, b_mwdata, b_mstrb;
  logic [0:0][3:0]   b_out;
  // Instance C: Latency 4, MaxOutstanding 2
  logic [0:0]        c_req, c_we, c_stall, c_mgnt, c_gnt, c_rvalid, c_mreq, c_mwe;
  logic [0:0][20:0]  c_addr, c_maddr;
  logic [0:0][31:0]  c_wdata, c_strb, c_mrdata, c_rdata, c_mwdata, c_mstrb;
  logic [0:0][3:0]   c_out;
  // Instance D: Latency 3, MaxOutstanding 2
  logic [0:0]        d_req, d_we, d_stall, d_mgnt, d_gnt, d_rvalid, d_mreq, d_mwe;
  logic [0:0][20:0]  d_addr, d_maddr;
  logic [0:0][31:0]  d_wdata, d_strb, d_mrdata, d_rdata, d_mwdata, d_mstrb;
  logic [0:0][3:0]   d_out;

  mem_lat_shim #(.NumPorts(2), .AddrW(21), .DataW(32), .Latency(1), .MaxOutstanding(2)) u_a (
    .clk_i(clk), .rst_i(rst), .req_i(a_req), .we_i(a_we), .addr_i(a_addr),
    .wdata_i(a_wdata), .strb_i(a_strb), .stall_i(a_stall), .gnt_o(a_gnt),
    .rdata_o(a_rdata), .rvalid_o(a_rvalid), .mem_req_o(a_mreq), .mem_we_o(a_mwe),
    .mem_addr_o(a_maddr), .mem_wdata_o(a_mwdata), .mem_strb_o(a_mstrb),
    .mem_gnt_i(a_mgnt), .mem_rdata_i(a_mrdata), .outstanding_o(a_out));

  mem_lat_shim #(.NumPorts(1), .AddrW(21), .DataW(32), .Latency(4), .MaxOutstanding(8)) u_b (
    .clk_i(clk), .rst_i(rst), .req_i(b_req), .we_i(b_we), .addr_i(b_addr),
    .wdata_i(b_wdata), .strb_i(b_strb), .stall_i(b_stall), .gnt_o(b_gnt),
    .rdata_o(b_rdata), .rvalid_o(b_rvalid), .mem_req_o(b_mreq), .mem_we_o(b_mwe),
    .mem_addr_o(b_maddr), .mem_wdata_o(b_mwdata), .mem_strb_o(b_mstrb),
    .mem_gnt_i(b_mgnt), .mem_rdata_i(b_mrdata), .outstanding_o(b_out));

  mem_lat_shim #(.NumPorts(1), .AddrW(21), .DataW(32), .Latency(4), .MaxOutstanding(2)) u_c (
    .clk_i(clk), .rst_i(rst), .req_i(c_req), .we_i(c_we), .addr_i(c_addr),
    .wdata_i(c_wdata), .strb_i(c_strb), .stall_i(c_stall), .gnt_o(c_gnt),
    .rdata_o(c_rdata), .rvalid_o(c_rvalid), .mem_req_o(c_mreq), .mem_we_o(c_mwe),
    .mem_addr_o(c_maddr), .mem_wdata_o(c_mwdata), .mem_strb_o(c_mstrb),
    .mem_gnt_i(c_mgnt), .mem_rdata_i(c_mrdata), .outstanding_o(c_out));

  mem_lat_shim #(.NumPorts(1), .AddrW(21), .DataW(32), .Latency(3), .MaxOutstanding(2)) u_d (
    .clk_i(clk), .rst_i(rst), .req_i(d_req), .we_i(d_we), .addr_i(d_addr),
    .wdata_i(d_wdata), .strb_i(d_strb), .stall_i(d_stall), .gnt_o(d_gnt),
    .rdata_o(d_rdata), .rvalid_o(d_rvalid), .mem_req_o(d_mreq), .mem_we_o(d_mwe),
    .mem_addr_o(d_maddr), .mem_wdata_o(d_mwdata), .mem_strb_o(d_mstrb),
    .mem_gnt_i(d_mgnt), .mem_rdata_i(d_mrdata), .outstanding_o(d_out));

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    rst = 1'b0;
    #1;
    checks++; if (a_rvalid !== 2'b00) begin failures++; $display("FAIL reset_a_rvalid actual=%b required=00", a_rvalid); end
    checks++; if (a_out !== 8'h00) begin failures++; $display("FAIL reset_a_outstanding actual=%h required=00", a_out); end
    checks++; if (b_rdata[0] !== 32'h0) begin failures++; $display("FAIL reset_b_rdata actual=%h required=0", b_rdata[0]); end
    checks++; if (b_rvalid !== 1'b0) begin failures++; $display("FAIL reset_b_rvalid actual=%b required=0", b_rvalid); end
    a_req = 2'b11; a_mgnt = 2'b11;
    #1;
    checks++; if (a_gnt !== 2'b11) begin failures++; $display("FAIL reset_a_gnt actual=%b required=11", a_gnt); end
    checks++; if (a_mreq !== 2'b11) begin failures++; $display("FAIL reset_a_mem_req actual=%b required=11", a_mreq); end
    a_req = 2'b00;
  endtask

  task automatic test_lat1_read();
    step();
    a_req[0] = 1'b1; a_we[0] = 1'b0; a_addr[0] = 21'h100;
    #1;
    checks++; if (a_gnt[0] !== 1'b1) begin failures++; $display("FAIL lat1_gnt actual=%b required=1", a_gnt[0]); end
    checks++; if (a_maddr[0] !== 21'h100) begin failures++; $display("FAIL lat1_mem_addr actual=%h required=100", a_maddr[0]); end
    checks++; if (a_rvalid[0] !== 1'b0) begin failures++; $display("FAIL lat1_rvalid_t actual=%b required=0", a_rvalid[0]); end
    step();
    a_req[0] = 1'b0; a_mrdata[0] = 32'hDEADBEEF;
    #1;
    checks++; if (a_rvalid !== 2'b01) begin failures++; $display("FAIL lat1_rvalid_t1 actual=%b required=01", a_rvalid); end
    checks++; if (a_rdata[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL lat1_rdata actual=%h required=deadbeef", a_rdata[0]); end
    checks++; if (a_out[0] !== 4'd1) begin failures++; $display("FAIL lat1_outstanding_t1 actual=%0d required=1", a_out[0]); end
    step();
    a_mrdata[0] = 32'h0;
    #1;
    checks++; if (a_rvalid[0] !== 1'b0) begin failures++; $display("FAIL lat1_rvalid_t2 actual=%b required=0", a_rvalid[0]); end
    checks++; if (a_out[0] !== 4'd0) begin failures++; $display("FAIL lat1_outstanding_t2 actual=%0d required=0", a_out[0]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd_tab [0:9];
    logic        v_tab  [0:9];
    logic [31:0] d_tab  [0:9];
    logic [3:0]  o_tab  [0:9];
    logic [3:0]  peak;
    rd_tab = '{32'h0, 32'h11, 32'h22, 32'h33, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    v_tab  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    d_tab  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h11, 32'h22, 32'h33, 32'h0, 32'h0, 32'h0};
    o_tab  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
    peak = 4'd0;
    for (int k = 0; k < 10; k++) begin
      step();
      b_req[0] = (k < 3); b_mrdata[0] = rd_tab[k];
      #1;
      if (b_out[0] > peak) peak = b_out[0];
      checks++; if (b_rvalid[0] !== v_tab[k]) begin failures++; $display("FAIL b2b_rvalid cycle=%0d actual=%b required=%b", k, b_rvalid[0], v_tab[k]); end
      checks++; if (b_out[0] !== o_tab[k]) begin failures++; $display("FAIL b2b_outstanding cycle=%0d actual=%0d required=%0d", k, b_out[0], o_tab[k]); end
      if (v_tab[k]) begin
        checks++; if (b_rdata[0] !== d_tab[k]) begin failures++; $display("FAIL b2b_rdata cycle=%0d actual=%h required=%h", k, b_rdata[0], d_tab[k]); end
      end
    end
    checks++; if (peak !== 4'd3) begin failures++; $display("FAIL b2b_peak actual=%0d required=3", peak); end
  endtask

  task automatic test_credit();
    logic       g_tab [0:7];
    logic [3:0] o_tab [0:7];
    g_tab = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    o_tab = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd2, 4'd1, 4'd1, 4'd2};
    for (int k = 0; k < 8; k++) begin
      step();
      c_req[0] = 1'b1;
      #1;
      checks++; if (c_gnt[0] !== g_tab[k]) begin failures++; $display("FAIL credit_gnt cycle=%0d actual=%b required=%b", k, c_gnt[0], g_tab[k]); end
      checks++; if (c_out[0] !== o_tab[k]) begin failures++; $display("FAIL credit_outstanding cycle=%0d actual=%0d required=%0d", k, c_out[0], o_tab[k]); end
    end
    c_req[0] = 1'b0;
  endtask

  task automatic test_write_mix();
    step();
    a_req[0] = 1'b1; a_we[0] = 1'b0; a_addr[0] = 21'h104;
    #1;
    checks++; if (a_gnt[0] !== 1'b1) begin failures++; $display("FAIL wmix_read_gnt actual=%b required=1", a_gnt[0]); end
    step();
    a_we[0] = 1'b1; a_addr[0] = 21'h200; a_wdata[0] = 32'hCAFEF00D; a_strb[0] = 32'h0000FFFF;
    #1;
    checks++; if (a_gnt[0] !== 1'b1) begin failures++; $display("FAIL wmix_write_gnt actual=%b required=1", a_gnt[0]); end
    checks++; if (a_mwe[0] !== 1'b1) begin failures++; $display("FAIL wmix_mem_we actual=%b required=1", a_mwe[0]); end
    checks++; if (a_mstrb[0] !== 32'h0000FFFF) begin failures++; $display("FAIL wmix_mem_strb actual=%h required=0000ffff", a_mstrb[0]); end
    checks++; if (a_mwdata[0] !== 32'hCAFEF00D) begin failures++; $display("FAIL wmix_mem_wdata actual=%h required=cafef00d", a_mwdata[0]); end
    checks++; if (a_rvalid[0] !== 1'b1) begin failures++; $display("FAIL wmix_read_rvalid actual=%b required=1", a_rvalid[0]); end
    step();
    a_req[0] = 1'b0; a_we[0] = 1'b0; a_strb[0] = 32'h0;
    #1;
    checks++; if (a_rvalid[0] !== 1'b0) begin failures++; $display("FAIL wmix_write_rvalid actual=%b required=0", a_rvalid[0]); end
    checks++; if (a_out[0] !== 4'd0) begin failures++; $display("FAIL wmix_outstanding actual=%0d required=0", a_out[0]); end
    step();
    #1;
    checks++; if (a_rvalid[0] !== 1'b0) begin failures++; $display("FAIL wmix_rvalid_late actual=%b required=0", a_rvalid[0]); end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 3; k++) begin
      step();
      a_req[1] = 1'b1; a_we[1] = 1'b0; a_stall[1] = 1'b1;
      a_req[0] = (k == 0);
      #1;
      checks++; if (a_gnt[1] !== 1'b0) begin failures++; $display("FAIL stall_gnt cycle=%0d actual=%b required=0", k, a_gnt[1]); end
      checks++; if (a_mreq[1] !== 1'b0) begin failures++; $display("FAIL stall_mem_req cycle=%0d actual=%b required=0", k, a_mreq[1]); end
      if (k == 0) begin
        checks++; if (a_gnt[0] !== 1'b1) begin failures++; $display("FAIL stall_other_port_gnt actual=%b required=1", a_gnt[0]); end
      end
    end
    step();
    a_stall[1] = 1'b0; a_req[0] = 1'b0;
    #1;
    checks++; if (a_gnt[1] !== 1'b1) begin failures++; $display("FAIL stall_release_gnt actual=%b required=1", a_gnt[1]); end
    step();
    a_req[1] = 1'b0;
    #1;
    checks++; if (a_rvalid !== 2'b10) begin failures++; $display("FAIL stall_release_rvalid actual=%b required=10", a_rvalid); end
  endtask

  task automatic test_reset_midflight();
    step();
    d_req[0] = 1'b1;
    #1;
    checks++; if (d_gnt[0] !== 1'b1) begin failures++; $display("FAIL rstmid_gnt0 actual=%b required=1", d_gnt[0]); end
    step();
    #1;
    checks++; if (d_gnt[0] !== 1'b1) begin failures++; $display("FAIL rstmid_gnt1 actual=%b required=1", d_gnt[0]); end
    step();
    d_req[0] = 1'b0; rst = 1'b1;
    #1;
    checks++; if (d_out[0] !== 4'd2) begin failures++; $display("FAIL rstmid_pre_outstanding actual=%0d required=2", d_out[0]); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (d_out[0] !== 4'd0) begin failures++; $display("FAIL rstmid_outstanding actual=%0d required=0", d_out[0]); end
    checks++; if (d_rvalid[0] !== 1'b0) begin failures++; $display("FAIL rstmid_rvalid cycle=0 actual=%b required=0", d_rvalid[0]); end
    for (int k = 1; k < 5; k++) begin
      step();
      #1;
      checks++; if (d_rvalid[0] !== 1'b0) begin failures++; $display("FAIL rstmid_rvalid cycle=%0d actual=%b required=0", k, d_rvalid[0]); end
    end
    // Cold read after reset: accept at k=0, data at k=1, rvalid at k=3.
    for (int k = 0; k < 5; k++) begin
      step();
      d_req[0] = (k == 0);
      d_mrdata[0] = (k == 1) ? 32'h00005A5A : 32'h0;
      #1;
      if (k == 0) begin
        checks++; if (d_gnt[0] !== 1'b1) begin failures++; $display("FAIL rstmid_cold_gnt actual=%b required=1", d_gnt[0]); end
      end
      checks++; if (d_rvalid[0] !== (k == 3)) begin failures++; $display("FAIL rstmid_cold_rvalid cycle=%0d actual=%b required=%b", k, d_rvalid[0], (k == 3)); end
      if (k == 3) begin
        checks++; if (d_rdata[0] !== 32'h00005A5A) begin failures++; $display("FAIL rstmid_cold_rdata actual=%h required=00005a5a", d_rdata[0]); end
      end
    end
  endtask

  initial begin
    a_req = '0; a_we = '0; a_stall = '0; a_mgnt = 2'b11; a_addr = '0; a_wdata = '0; a_strb = '0; a_mrdata = '0;
    b_req = '0; b_we = '0; b_stall = '0; b_mgnt = 1'b1;  b_addr = '0; b_wdata = '0; b_strb = '0; b_mrdata = '0;
    c_req = '0; c_we = '0; c_stall = '0; c_mgnt = 1'b1;  c_addr = '0; c_wdata = '0; c_strb = '0; c_mrdata = '0;
    d_req = '0; d_we = '0; d_stall = '0; d_mgnt = 1'b1;  d_addr = '0; d_wdata = '0; d_strb = '0; d_mrdata = '0;
    rst = 1'b1;
    step();
    step();
    test_reset();
    test_lat1_read();
    test_back_to_back();
    test_credit();
    test_write_mix();
    test_stall();
    test_reset_midflight();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
